// File: rtl/jk_reg_array.sv
// rtl/jk_reg_array.sv - WIDTH-bit bank of JK cells with JK, count-up, count-down and load modes
//
// Every mode is mapped onto per-bit J/K drives feeding one shared JK next-state
// equation, so the register behaves as a bank of JK flip-flops in all modes.
//
// Ports:
//   clk   - clock, all state updates on rising edge
//   rst   - asynchronous active-high reset (q = RESET_VAL, chg = 0)
//   en    - cycle enable; 0 holds every bit
//   mode  - 00 JK, 01 count up, 10 count down, 11 parallel load
//   j, k  - per-bit JK inputs (mode 00)
//   d     - parallel load data (mode 11)
//   q     - register state
//   qbar  - complement of q (derived, not stored)
//   tc    - terminal count, combinational: next count edge wraps/saturates
//   chg   - registered pulse: q changed on the previous edge
//
// Build option: define JK_SAT_EN to make the count modes saturate at the
// boundary instead of wrapping.

module jk_reg_array #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             chg
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] tog_up;
    logic [WIDTH-1:0] tog_dn;
    logic [WIDTH-1:0] jj;
    logic [WIDTH-1:0] kk;
    logic [WIDTH-1:0] next_q;
    logic             chg_r;
    logic             all_ones;
    logic             all_zero;
    logic             sat_hold;

    assign all_ones = &q_r;
    assign all_zero = ~|q_r;

    // Toggle chains: up-count bit i toggles when all lower bits are 1,
    // down-count bit i toggles when all lower bits are 0.
    always_comb begin
        tog_up    = '0;
        tog_dn    = '0;
        tog_up[0] = 1'b1;
        tog_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tog_up[i] = tog_up[i-1] & q_r[i-1];
            tog_dn[i] = tog_dn[i-1] & ~q_r[i-1];
        end
    end

`ifdef JK_SAT_EN
    // At the count boundary the toggle drives are suppressed so q holds.
    assign sat_hold = ((mode == MODE_UP) & all_ones) | ((mode == MODE_DOWN) & all_zero);
`else
    assign sat_hold = 1'b0;
`endif

    // Per-mode J/K drive. Load uses j=d, k=~d, which forces each bit to d.
    always_comb begin
        jj = '0;
        kk = '0;
        if (en) begin
            case (mode)
                MODE_JK: begin
                    jj = j;
                    kk = k;
                end
                MODE_UP: begin
                    if (!sat_hold) begin
                        jj = tog_up;
                        kk = tog_up;
                    end
                end
                MODE_DOWN: begin
                    if (!sat_hold) begin
                        jj = tog_dn;
                        kk = tog_dn;
                    end
                end
                MODE_LOAD: begin
                    jj = d;
                    kk = ~d;
                end
                default: begin
                    jj = '0;
                    kk = '0;
                end
            endcase
        end
    end

    // Characteristic JK equation applied to every bit.
    assign next_q = (jj & ~q_r) | (~kk & q_r);

    assign tc = en & (((mode == MODE_UP) & all_ones) | ((mode == MODE_DOWN) & all_zero));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r   <= RESET_VAL;
            chg_r <= 1'b0;
        end else begin
            q_r   <= next_q;
            chg_r <= en & (next_q != q_r);
        end
    end

    assign q    = q_r;
    assign qbar = ~q_r;
    assign chg  = chg_r;

endmodule
